// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM behind the core's data port, programmable read latency.
// Optional macro DMEM_BOUNDS_CHECK_EN faults accesses outside the mapped window.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] dReadData,
    output logic        dReady,
    output logic        dErr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          fault_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          fault;
    logic          req;
    logic          accept;
    logic          unused_bits;

    assign offset      = dAddress - BASE_ADDR;
    assign idx         = offset[AW+1:2];
    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
    assign req         = MemRead | MemWrite;
    assign accept      = (state == IDLE) && req;

`ifdef DMEM_BOUNDS_CHECK_EN
    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    assign fault = (dAddress[1:0] != 2'b00) || (offset >= 32'(4 * DEPTH_WORDS));
`else
    assign fault = (dAddress[1:0] != 2'b00);
`endif

    // RAM has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && accept && MemWrite && !fault)
            mem[idx] <= dWriteData;
    end

    // Handshake outputs rise one edge after DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            fault_q   <= 1'b0;
            dReadData <= 32'h0;
            dReady    <= 1'b0;
            dErr      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= idx;
                        fault_q <= fault;
                        if (MemWrite) begin
                            state <= DONE;
                        end else if (READ_LATENCY == 1) begin
                            dReadData <= fault ? 32'h0 : mem[idx];
                            state     <= DONE;
                        end else begin
                            cnt   <= 4'(READ_LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        dReadData <= fault_q ? 32'h0 : mem[idx_q];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (req) begin
                        dReady <= 1'b1;
                        dErr   <= fault_q;
                    end else begin
                        dReady <= 1'b0;
                        dErr   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors for data_mem_responder at read latency 2 and 4.
// Expected values follow DMEM_BOUNDS_CHECK_EN when it is defined.
module tb_data_mem_responder;
    localparam logic [31:0] B = 32'h10010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst4, rd, wr, rd4, wr4;
    logic [31:0] addr, wdata, rdata, rdata4;
    logic        rdy, err, rdy4, err4;
    int          n_cmp = 0;
    int          n_bad = 0;

    data_mem_responder #(.READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .dAddress(addr), .dWriteData(wdata),
        .MemRead(rd), .MemWrite(wr), .dReadData(rdata),
        .dReady(rdy), .dErr(err)
    );

    data_mem_responder #(.READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4), .dAddress(addr), .dWriteData(wdata),
        .MemRead(rd4), .MemWrite(wr4), .dReadData(rdata4),
        .dReady(rdy4), .dErr(err4)
    );

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        e;
        logic [31:0] q;
        bit          chkq;
    } vec_t;

    vec_t v[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Returns cycles from accept edge to dReady, or -1 on timeout.
    task automatic access(input bit sel, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e,
                          output logic [31:0] q);
        @(negedge clk);
        addr  = a;
        wdata = d;
        if (sel) begin wr4 = w; rd4 = r; end
        else begin wr = w; rd = r; end
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel ? rdy4 : rdy) === 1'b1) begin
                lat = i;
                break;
            end
        end
        e = sel ? err4 : err;
        q = sel ? rdata4 : rdata;
    endtask

    task automatic drop(input bit sel, input string name);
        if (sel) begin wr4 = 1'b0; rd4 = 1'b0; end
        else begin wr = 1'b0; rd = 1'b0; end
        @(negedge clk);
        check({name, " ready_clear"}, sel ? rdy4 : rdy, 32'd0);
        check({name, " err_clear"}, sel ? err4 : err, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic        e;
        logic [31:0] q;

        rst = 1'b1; rst4 = 1'b1;
        rd = 1'b0; wr = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
        addr = 32'h0; wdata = 32'h0;

        v.push_back('{1, 0, B + 32'h8,   32'hDEADBEEF, 1, 0, 32'h0, 0});
        v.push_back('{0, 1, B + 32'h8,   32'h0,        2, 0, 32'hDEADBEEF, 1});
        v.push_back('{1, 0, B,           32'h11111111, 1, 0, 32'h0, 0});
        v.push_back('{1, 0, B + 32'h2,   32'h12345678, 1, 1, 32'h0, 0});
        v.push_back('{0, 1, B,           32'h0,        2, 0, 32'h11111111, 1});
        v.push_back('{1, 1, B + 32'h4,   32'hA5A5A5A5, 1, 0, 32'h0, 0});
        v.push_back('{0, 1, B + 32'h4,   32'h0,        2, 0, 32'hA5A5A5A5, 1});
        v.push_back('{0, 1, B + 32'h1,   32'h0,        2, 1, 32'h0, 1});
        v.push_back('{1, 0, B + 32'h3FC, 32'hCAFEF00D, 1, 0, 32'h0, 0});
        v.push_back('{0, 1, B + 32'h3FC, 32'h0,        2, 0, 32'hCAFEF00D, 1});
`ifdef DMEM_BOUNDS_CHECK_EN
        v.push_back('{0, 1, B + 32'h400, 32'h0,        2, 1, 32'h0, 1});
        v.push_back('{0, 1, B - 32'h4,   32'h0,        2, 1, 32'h0, 1});
`else
        v.push_back('{0, 1, B + 32'h400, 32'h0,        2, 0, 32'h11111111, 1});
        v.push_back('{0, 1, B - 32'h4,   32'h0,        2, 0, 32'hCAFEF00D, 1});
`endif
        v.push_back('{0, 1, B + 32'h8,   32'h0,        2, 0, 32'hDEADBEEF, 1});

        repeat (3) @(negedge clk);
        check("reset ready", rdy, 32'd0);
        check("reset err", err, 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset rdata4", rdata4, 32'h0);
        rst = 1'b0; rst4 = 1'b0;

        // Reset while latency-4 read is waiting: abort, data untouched.
        @(negedge clk);
        addr = B + 32'h8;
        rd4  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        check("rst_wait ready", rdy4, 32'd0);
        check("rst_wait rdata", rdata4, 32'h0);
        rd4  = 1'b0;
        rst4 = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wait idle ready", rdy4, 32'd0);
        check("rst_wait idle rdata", rdata4, 32'h0);

        access(1, 1, 0, B, 32'h0BADCAFE, lat, e, q);
        check("l4 write lat", lat, 32'd1);
        check("l4 write err", e, 32'd0);
        drop(1, "l4 write");
        access(1, 0, 1, B, 32'h0, lat, e, q);
        check("l4 read lat", lat, 32'd4);
        check("l4 read err", e, 32'd0);
        check("l4 read data", q, 32'h0BADCAFE);
        drop(1, "l4 read");

        for (int i = 0; i < v.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            access(0, v[i].w, v[i].r, v[i].a, v[i].d, lat, e, q);
            check({nm, " lat"}, lat, v[i].lat);
            check({nm, " err"}, e, v[i].e);
            if (v[i].chkq) check({nm, " data"}, q, v[i].q);
            drop(0, nm);
        end

        // Held request: one access only; later address changes ignored.
        access(0, 0, 1, B + 32'h8, 32'h0, lat, e, q);
        check("hold lat", lat, 32'd2);
        addr = B + 32'h4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold ready c%0d", i), rdy, 32'd1);
            check($sformatf("hold data c%0d", i), rdata, 32'hDEADBEEF);
        end
        drop(0, "hold");
        @(negedge clk);
        check("hold no retrigger", rdy, 32'd0);
        check("hold data kept", rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Data-memory responder for the multicycle RISC-V core: the memory-side end of the processor's `dAddress` / `dWriteData` / `MemRead` / `MemWrite` / `dReadData` data port.
- Holds a word-organised RAM and serves one access at a time, with a programmable read latency and a level-based ready/err handshake.
- Sits beside the processor top in the system testbench and SoC wrapper.

## Interface
- `BASE_ADDR`, default 32'h10010000: byte address of word 0.
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words; must be a power of two, at least 2.
- `READ_LATENCY`, default 2: cycles from accept to read data valid; legal range 1..15.
- `clk` input 1: the only clock.
- `rst` input 1: reset, synchronous and active-high. Clears control state and outputs; RAM contents are retained.
- `dAddress` input 32: byte address of the access.
- `dWriteData` input 32: store data.
- `MemRead` input 1: read request (level).
- `MemWrite` input 1: write request (level); has priority over `MemRead`.
- `dReadData` output 32: read data, held until the next read completes.
- `dReady` output 1: access complete (level); stays high until the request drops.
- `dErr` output 1: the completed access faulted; valid while `dReady` is high.

## Operation
- States: IDLE, WAIT, DONE.
- **Word index:** `(dAddress - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits. 32-bit subtraction, modulo 2^32.
- **IDLE:**
  - Accept when `MemWrite` or `MemRead` is high. Capture address, write data and op type (write if `MemWrite`, else read).
  - If both requests are high, the access is a write; no error is flagged for this.
- **Write:**
  - Committed to RAM on the accept edge, unless faulted.
  - Next state DONE.
- **Read:**
  - Next state WAIT, with the latency counter loaded to READ_LATENCY-1.
  - WAIT decrements the counter each cycle.
  - At counter 0 (or directly from IDLE when READ_LATENCY=1), `dReadData` is loaded from RAM and the block enters DONE.
- **Faults:**
  - Misaligned access (`dAddress[1:0] != 0`): write suppressed; read loads `dReadData` = 0; `dErr` = 1.
  - Faulted accesses keep the same latency as good ones.
- **DONE:**
  - `dReady` = 1; `dErr` reflects the access.
  - Return to IDLE only when `MemRead` and `MemWrite` are both low. A request held high never re-triggers.
  - On the edge that leaves DONE, `dReady` and `dErr` clear.
- **Input changes:** changes on `dAddress` / `dWriteData` / request lines in WAIT or DONE are ignored, apart from the DONE drop check.
- **Read-after-write:** a read of a just-written word returns the new value.

## Timing
- **Reset:** state IDLE, `dReady` = 0, `dErr` = 0, `dReadData` = 32'h0.
- **Reset mid-operation:**
  - A read in WAIT is aborted and `dReadData` is not updated.
  - A write already committed at accept remains in RAM.
- **Read:** accept at edge E0; `dReadData`, `dReady` and `dErr` are valid after edge E0+READ_LATENCY.
- **Write:** accept at edge E0; RAM updated at E0; `dReady` is high after edge E0+1, independent of READ_LATENCY.
- **Back-to-back:** the earliest next accept is the edge after the one where the requests are seen low in DONE. Minimum spacing is 2 cycles between a done state and the next accept.
- **RAM:** synchronous write; read sampled at the completion edge.

## Configuration
- `DMEM_BOUNDS_CHECK_EN` defined:
  - Addresses below `BASE_ADDR` or at or above `BASE_ADDR + 4*DEPTH_WORDS` are faults.
  - Fault behaviour: `dErr` = 1, write suppressed, read returns 0.
- Not defined:
  - No range check; the index wraps modulo DEPTH_WORDS (aliasing).
  - `dErr` is driven only by misalignment.

## Test plan
- **Write/read, latency 2:** write 32'hDEADBEEF at BASE_ADDR+8, drop the request, then read BASE_ADDR+8.
  - Write: `dReady` high 1 cycle after accept.
  - Read: `dReady` high exactly 2 cycles after accept, `dReadData` = 32'hDEADBEEF, `dErr` = 0.
- **Misaligned write:** write 32'h12345678 at BASE_ADDR+2 → `dErr` = 1; a following read of BASE_ADDR returns the old value.
- **Both requests high:** `MemRead` and `MemWrite` high at BASE_ADDR+4 with data 32'hA5A5A5A5 → treated as a write, `dErr` = 0; a later read returns 32'hA5A5A5A5.
- **Held request:** hold `MemRead` high for 10 cycles after DONE → a single access only; `dReady` stays 1 throughout and clears one cycle after `MemRead` falls.
- **Reset during WAIT:** read with READ_LATENCY=4, assert `rst` at cycle 2 → next cycle `dReady` = 0, state IDLE, `dReadData` unchanged at 0.
- **Out-of-range address:** read BASE_ADDR+4*DEPTH_WORDS.
  - With `DMEM_BOUNDS_CHECK_EN`: `dErr` = 1, data 0.
  - Without: returns the word at index 0.
